// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, control bundle type and register-usage helpers
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  typedef struct packed {
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] alu_op;
    logic [1:0] mem_to_reg;
  } ctrl_bundle_t;
  localparam ctrl_bundle_t CTRL_BUBBLE = '0;
  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_S, OP_I, OP_L, OP_B, OP_JALR};
  endfunction
  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_S, OP_B};
  endfunction
endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg: async-reset pipeline register of {valid, control bundle, rd} with bubble insert
module ctrl_stage_reg
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubble,
  input  logic                  d_valid,
  input  ctrl_bundle_t          d_ctrl,
  input  logic [REG_ADDR_W-1:0] d_rd,
  output logic                  q_valid,
  output ctrl_bundle_t          q_ctrl,
  output logic [REG_ADDR_W-1:0] q_rd
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_BUBBLE;
      q_rd    <= '0;
    end else begin
      q_valid <= bubble ? 1'b0 : d_valid;
      q_ctrl  <= bubble ? CTRL_BUBBLE : d_ctrl;
      q_rd    <= bubble ? '0 : d_rd;
    end
endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: ID->EX->MEM control pipeline with load-use stall and branch flush
// Optional perf counters enabled by defining CTRL_PERF_CNT_EN.
module ctrl_pipe_hazard
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
`ifdef CTRL_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic                  id_alu_src,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_reg_write,
  input  logic                  id_mem_write,
  input  logic [1:0]            id_alu_op,
  input  logic [1:0]            id_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_reg_write,
  output logic                  ex_mem_write,
  output logic [1:0]            ex_alu_op,
  output logic [1:0]            ex_mem_to_reg,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_valid,
  output logic                  mem_alu_src,
  output logic                  mem_branch,
  output logic                  mem_mem_read,
  output logic                  mem_reg_write,
  output logic                  mem_mem_write,
  output logic [1:0]            mem_alu_op,
  output logic [1:0]            mem_mem_to_reg,
  output logic [REG_ADDR_W-1:0] mem_rd
`ifdef CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0]    perf_stall_cnt
  , output logic [CNT_W-1:0]    perf_flush_cnt
`endif
);
  ctrl_bundle_t id_ctrl, ex_ctrl, mem_ctrl;
  logic load_use;
  // mem_to_reg is forced to 00 when nothing is written back so an X never enters the pipe
  assign id_ctrl = '{alu_src: id_alu_src, branch: id_branch, mem_read: id_mem_read,
                     reg_write: id_reg_write, mem_write: id_mem_write, alu_op: id_alu_op,
                     mem_to_reg: id_reg_write ? id_mem_to_reg : 2'b00};
  assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                    ((uses_rs1(id_opcode) & (id_rs1 == ex_rd)) |
                     (uses_rs2(id_opcode) & (id_rs2 == ex_rd)));
  assign stall = load_use & ~ex_branch_taken;
  ctrl_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_ex (
    .clk(clk), .rst(rst), .bubble(ex_branch_taken | stall | ~id_valid),
    .d_valid(id_valid), .d_ctrl(id_ctrl), .d_rd(id_rd),
    .q_valid(ex_valid), .q_ctrl(ex_ctrl), .q_rd(ex_rd)
  );
  ctrl_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_mem (
    .clk(clk), .rst(rst), .bubble(1'b0),
    .d_valid(ex_valid), .d_ctrl(ex_ctrl), .d_rd(ex_rd),
    .q_valid(mem_valid), .q_ctrl(mem_ctrl), .q_rd(mem_rd)
  );
  assign {ex_alu_src, ex_branch, ex_mem_read, ex_reg_write, ex_mem_write, ex_alu_op,
          ex_mem_to_reg} = ex_ctrl;
  assign {mem_alu_src, mem_branch, mem_mem_read, mem_reg_write, mem_mem_write, mem_alu_op,
          mem_mem_to_reg} = mem_ctrl;
`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + CNT_W'(stall);
      perf_flush_cnt <= perf_flush_cnt + CNT_W'(ex_branch_taken);
    end
`endif
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb_ctrl_pipe_hazard: table-driven check of stall/flush/bubble behaviour plus reset and counter sequences
module tb_ctrl_pipe_hazard;
  localparam logic [6:0] OP_R = 7'b0110011, OP_S = 7'b0100011, OP_L = 7'b0000011;
  localparam logic [6:0] OP_B = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [8:0] LW   = 9'b1_0_1_1_0_00_01;
  localparam logic [8:0] ADD  = 9'b0_0_0_1_0_10_00;
  localparam logic [8:0] SW   = 9'b1_0_0_0_1_00_xx;
  localparam logic [8:0] SWE  = 9'b1_0_0_0_1_00_00;
  localparam logic [8:0] JAL  = 9'b0_0_0_1_0_00_10;
  localparam logic [8:0] BEQ  = 9'b0_1_0_0_0_01_xx;
  localparam logic [8:0] BEQE = 9'b0_1_0_0_0_01_00;
  localparam logic [8:0] Z    = 9'b0;
  logic clk = 0, rst = 1;
  logic id_valid, id_alu_src, id_branch, id_mem_read, id_reg_write, id_mem_write, ex_branch_taken;
  logic [6:0] id_opcode;
  logic [1:0] id_alu_op, id_mem_to_reg;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic stall, ex_valid, ex_alu_src, ex_branch, ex_mem_read, ex_reg_write, ex_mem_write;
  logic [1:0] ex_alu_op, ex_mem_to_reg, mem_alu_op, mem_mem_to_reg;
  logic [4:0] ex_rd, mem_rd;
  logic mem_valid, mem_alu_src, mem_branch, mem_mem_read, mem_reg_write, mem_mem_write;
  int checks = 0, errors = 0;
`ifdef CTRL_PERF_CNT_EN
  logic [3:0] perf_stall_cnt, perf_flush_cnt;
  ctrl_pipe_hazard #(.REG_ADDR_W(5), .CNT_W(4)) dut (
`else
  ctrl_pipe_hazard #(.REG_ADDR_W(5)) dut (
`endif
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .id_mem_write(id_mem_write), .id_alu_op(id_alu_op), .id_mem_to_reg(id_mem_to_reg),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_alu_op(ex_alu_op), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_alu_src(mem_alu_src), .mem_branch(mem_branch),
    .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_alu_op(mem_alu_op), .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd)
`ifdef CTRL_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [6:0] op; logic [8:0] ctl; logic [4:0] rs1, rs2, rd; logic tk;
    logic e_stall, e_exv; logic [8:0] e_exc; logic [4:0] e_exrd; logic e_memv; logic [4:0] e_memrd;
  } vec_t;
  vec_t tbl[16];
  function automatic vec_t mk(logic v, logic [6:0] op, logic [8:0] ctl, logic [4:0] rs1, rs2, rd,
                              logic tk, logic es, logic ev, logic [8:0] ec, logic [4:0] erd,
                              logic mv, logic [4:0] mrd);
    vec_t t;
    t.v = v; t.op = op; t.ctl = ctl; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.tk = tk;
    t.e_stall = es; t.e_exv = ev; t.e_exc = ec; t.e_exrd = erd; t.e_memv = mv; t.e_memrd = mrd;
    return t;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drv(logic v, logic [6:0] op, logic [8:0] ctl, logic [4:0] rs1, rs2, rd, logic tk);
    id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; ex_branch_taken = tk;
    {id_alu_src, id_branch, id_mem_read, id_reg_write, id_mem_write, id_alu_op, id_mem_to_reg} = ctl;
  endtask
  function automatic logic [8:0] exc();
    return {ex_alu_src, ex_branch, ex_mem_read, ex_reg_write, ex_mem_write, ex_alu_op, ex_mem_to_reg};
  endfunction
  function automatic logic [8:0] memc();
    return {mem_alu_src, mem_branch, mem_mem_read, mem_reg_write, mem_mem_write, mem_alu_op,
            mem_mem_to_reg};
  endfunction
  initial begin
    tbl[0]  = mk(1, OP_L,   LW,  1, 0, 5, 0,  0, 1, LW,   5, 0, 0);
    tbl[1]  = mk(1, OP_R,   ADD, 5, 7, 6, 0,  1, 0, Z,    0, 1, 5);
    tbl[2]  = mk(1, OP_R,   ADD, 5, 7, 6, 0,  0, 1, ADD,  6, 0, 0);
    tbl[3]  = mk(1, OP_L,   LW,  1, 0, 0, 0,  0, 1, LW,   0, 1, 6);
    tbl[4]  = mk(1, OP_R,   ADD, 0, 0, 6, 0,  0, 1, ADD,  6, 1, 0);
    tbl[5]  = mk(1, OP_L,   LW,  1, 0, 5, 0,  0, 1, LW,   5, 1, 6);
    tbl[6]  = mk(1, OP_JAL, JAL, 5, 5, 1, 0,  0, 1, JAL,  1, 1, 5);
    tbl[7]  = mk(1, OP_L,   LW,  2, 0, 5, 0,  0, 1, LW,   5, 1, 1);
    tbl[8]  = mk(1, OP_R,   ADD, 5, 7, 6, 1,  0, 0, Z,    0, 1, 5);
    tbl[9]  = mk(1, OP_S,   SW,  2, 3, 0, 0,  0, 1, SWE,  0, 0, 0);
    tbl[10] = mk(0, OP_R,   ADD, 5, 5, 6, 0,  0, 0, Z,    0, 1, 0);
    tbl[11] = mk(1, OP_L,   LW,  1, 0, 7, 0,  0, 1, LW,   7, 0, 0);
    tbl[12] = mk(1, OP_L,   LW,  7, 0, 8, 0,  1, 0, Z,    0, 1, 7);
    tbl[13] = mk(1, OP_L,   LW,  7, 0, 8, 0,  0, 1, LW,   8, 0, 0);
    tbl[14] = mk(1, OP_B,   BEQ, 9, 8, 0, 0,  1, 0, Z,    0, 1, 8);
    tbl[15] = mk(1, OP_B,   BEQ, 9, 8, 0, 0,  0, 1, BEQE, 0, 0, 0);
    drv(0, OP_R, Z, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_ex_valid", {31'b0, ex_valid}, 0);
    chk("reset_ex_ctl", {23'b0, exc()}, 0);
    chk("reset_mem", {26'b0, mem_valid, mem_rd}, 0);
    for (int i = 0; i < 16; i++) begin
      drv(tbl[i].v, tbl[i].op, tbl[i].ctl, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].tk);
      #1 chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].e_stall});
      @(posedge clk); #1;
      chk($sformatf("v%0d_ex_valid", i), {31'b0, ex_valid}, {31'b0, tbl[i].e_exv});
      chk($sformatf("v%0d_ex_ctl", i), {23'b0, exc()}, {23'b0, tbl[i].e_exc});
      chk($sformatf("v%0d_ex_rd", i), {27'b0, ex_rd}, {27'b0, tbl[i].e_exrd});
      chk($sformatf("v%0d_mem_valid", i), {31'b0, mem_valid}, {31'b0, tbl[i].e_memv});
      chk($sformatf("v%0d_mem_rd", i), {27'b0, mem_rd}, {27'b0, tbl[i].e_memrd});
      chk($sformatf("v%0d_mem_ctl", i), {23'b0, memc()}, {23'b0, i == 0 ? Z : tbl[i-1].e_exc});
    end
`ifdef CTRL_PERF_CNT_EN
    chk("perf_stall_after_table", {28'b0, perf_stall_cnt}, 3);
    chk("perf_flush_after_table", {28'b0, perf_flush_cnt}, 1);
`endif
    drv(1, OP_R, ADD, 1, 2, 3, 0);
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_mem_valid", {31'b0, mem_valid}, 1);
    rst = 1;
    #1;
    chk("async_rst_ex", {26'b0, ex_valid, ex_rd}, 0);
    chk("async_rst_ctl", {14'b0, exc(), memc()}, 0);
    chk("async_rst_mem", {26'b0, mem_valid, mem_rd}, 0);
    chk("async_rst_stall", {31'b0, stall}, 0);
`ifdef CTRL_PERF_CNT_EN
    chk("async_rst_cnt", {24'b0, perf_stall_cnt, perf_flush_cnt}, 0);
`endif
    rst = 0;
    drv(1, OP_R, ADD, 1, 2, 6, 0);
    @(posedge clk); #1;
    chk("post_rst_ex", {26'b0, ex_valid, ex_rd}, {26'b0, 1'b1, 5'd6});
    chk("post_rst_mem", {31'b0, mem_valid}, 0);
    for (int i = 0; i < 17; i++) begin
      drv(1, OP_L, LW, 1, 0, 5, 0);
      @(posedge clk); #1;
      drv(1, OP_R, ADD, 5, 7, 6, 0);
      #1 chk($sformatf("wrap_stall_%0d", i), {31'b0, stall}, 1);
      @(posedge clk); #1;
    end
`ifdef CTRL_PERF_CNT_EN
    chk("perf_stall_wrap", {28'b0, perf_stall_cnt}, 1);
    chk("perf_flush_zero", {28'b0, perf_flush_cnt}, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
